sram_cmd_ctl: RTL and testbench
===============================

Name: sram_cmd_ctl

Overview:
Command engine directly downstream of the Wishbone slave bridge. It consumes the bridge's cmd_val/cmd_adr/cmd_we/cmd_sel/cmd_dat stream and returns rd_ack/rd_dat. It drives the toy SRAM array's separate read and write ports, and implements byte-lane writes as read-modify-write because the array has no byte enables. It also holds a small control-register window and a 1-deep command holding register, so a command that arrives while the engine is busy is not lost.

Parameters:
ADDR_W, 6, array word-address width; word address = cmd_adr[ADDR_W+1:2]
RD_LAT, 1, array read latency in cycles, from arr_rd_enb to valid arr_rd_dat (legal range 1..4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cmd_val  in  1  command valid, level, from bridge
cmd_adr  in  32  command address; [27]=1 selects control window
cmd_we  in  1  1=write, 0=read
cmd_sel  in  4  byte enables (write only)
cmd_dat  in  32  write data
rd_ack  out  1  read complete, 1-cycle pulse
rd_dat  out  32  read data, registered, held between acks
arr_rd_enb  out  1  array read enable
arr_rd_adr  out  ADDR_W  array read address
arr_rd_dat  in  32  array read data
arr_wr_enb  out  1  array write enable
arr_wr_adr  out  ADDR_W  array write address
arr_wr_dat  out  32  array write data

Behaviour:
- Reset (rst=0, asynchronous): every register clears. All outputs are 0. State=IDLE, holding register empty, OVF=0, SCRATCH=0, previous-cmd_val flop=0. An in-flight operation is abandoned and produces no rd_ack and no array write.
- Acceptance: a command is recognised only on a cmd_val rising edge (cmd_val=1 and previous-cycle cmd_val=0). The bridge holds cmd_val high across a read until after rd_ack, so a level is never re-accepted.
- Routing of a recognised command:
  - IDLE and holding register empty: the command starts directly.
  - Otherwise it is written to the holding register.
  - Holding register full and not being drained this cycle: the command is dropped and OVF is set (sticky).
- IDLE priority: the holding register first, then a new command. If the holding register drains in the same cycle a new command rises, the new command goes into the freed slot.
- FSM states: IDLE, RD_WAIT, RMW_WAIT, RMW_WR. Cycle 0 is the cycle the command starts. All arr_* outputs are registered.
- Array read: arr_rd_enb=1 in cycle 1. The engine waits RD_LAT cycles in RD_WAIT, latches arr_rd_dat into rd_dat, and pulses rd_ack in cycle 2+RD_LAT. cmd_sel is ignored and the full word is returned.
- Full write (sel=4'hF): arr_wr_enb=1 in cycle 1 with adr/dat; no wait.
- Partial write (sel other than 0 and F): arr_rd_enb in cycle 1, then RMW_WAIT for RD_LAT cycles. The merge takes cmd_dat bytes where sel=1 and read bytes elsewhere. arr_wr_enb with the merged data is driven in cycle 2+RD_LAT via RMW_WR.
- Write with sel=0: no array access; completes in cycle 0.
- Writes never produce rd_ack, because the bridge self-acks writes.
- Enable pulses: arr_rd_enb and arr_wr_enb are single-cycle pulses. Addresses and data hold their last value when the enable is 0.
- Next start: the engine returns to IDLE and may start the next command in the cycle after its last array pulse or rd_ack.
- Control window (cmd_adr[27]=1), register index cmd_adr[2]; no array access:
  - Index 0, STATUS: bit0 OVF, bit1 holding register full, bit2 busy (state != IDLE); other bits 0. Writing with sel[0]=1 and dat[0]=1 clears OVF.
  - Index 1, SCRATCH: read/write, byte enables honoured.
  - Control read: rd_ack in cycle 1. Control write: takes effect at the end of cycle 0.
- Simultaneous events: OVF set (a drop) and OVF clear (a write) in the same cycle results in OVF=1.
- Hazard ordering: a write in the holding register always executes before any later command, so read-after-write to the same address returns the new data.
- Address: cmd_adr bits [31:28] are ignored. Array address bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^ADDR_W words.

Test Plan:
- Reset with rst=0 mid-RD_WAIT → no rd_ack; all outputs 0; STATUS reads 0 after release.
- Full write of 0xDEADBEEF to adr 0x30000010 → arr_wr_enb in cycle 1, arr_wr_adr=4. A later read of 0x10 with RD_LAT=1 → arr_rd_enb in cycle 1, rd_ack in cycle 3, rd_dat=0xDEADBEEF.
- Array word 4 = 0x11223344; write sel=4'b0101, dat=0xAABBCCDD → arr_rd_enb in cycle 1, arr_wr_enb in cycle 3 with 0x11BB33DD.
- Partial write busy, then a read of the same address rises → read is held and issues after the RMW write → rd_data returns the merged value.
- RMW busy, holding register full, another write rises → dropped; STATUS=0x7 while busy. Then write STATUS dat=1 → OVF clears and STATUS reads 0x0 when idle.
- Write SCRATCH sel=4'b0011, dat=0x12345678 → read of SCRATCH returns 0x00005678 with rd_ack in cycle 1. Read of 0x30000100 with ADDR_W=6 → arr_rd_adr=0 (wrap).

Source files
------------

// File: rtl/sram_cmd_ctl.sv
// Command engine between the Wishbone bridge and the toy SRAM array: reads, byte-lane
// writes done as read-modify-write, a 1-deep holding register and a small control window.
module sram_cmd_ctl #(
   parameter int ADDR_W = 6,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_val,
   input  logic [31:0]       cmd_adr,
   input  logic              cmd_we,
   input  logic [3:0]        cmd_sel,
   input  logic [31:0]       cmd_dat,
   output logic              rd_ack,
   output logic [31:0]       rd_dat,
   output logic              arr_rd_enb,
   output logic [ADDR_W-1:0] arr_rd_adr,
   input  logic [31:0]       arr_rd_dat,
   output logic              arr_wr_enb,
   output logic [ADDR_W-1:0] arr_wr_adr,
   output logic [31:0]       arr_wr_dat
);

   // state    | meaning
   // IDLE     | no operation in flight; may start held or new command
   // RD_WAIT  | array read issued, counting down read latency
   // RMW_WAIT | partial write: old word being read, counting down latency
   // RMW_WR   | merged word being written to the array
   typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WAIT, RMW_WR} state_t;

   localparam logic [2:0] LAT = 3'(RD_LAT);

   state_t            state;
   logic [2:0]        cnt;
   logic              prev_val;
   logic              ovf;
   logic [31:0]       scratch;
   logic [3:0]        w_sel;
   logic [31:0]       w_dat;

   logic              hold_full;
   logic              hold_ctl;
   logic              hold_idx;
   logic [ADDR_W-1:0] hold_wadr;
   logic              hold_we;
   logic [3:0]        hold_sel;
   logic [31:0]       hold_dat;

   logic              rise, idle, direct, drain, start, store, drop, ovf_clr;
   logic              s_ctl, s_idx, s_we;
   logic [ADDR_W-1:0] s_wadr;
   logic [3:0]        s_sel;
   logic [31:0]       s_dat;
   logic [31:0]       status_val;
   logic              unused_adr;

   function automatic logic [31:0] merge(input logic [3:0] sel, input logic [31:0] nd,
                                         input logic [31:0] od);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = sel[i] ? nd[8*i +: 8] : od[8*i +: 8];
      return r;
   endfunction

   assign rise    = cmd_val & ~prev_val;
   assign idle    = (state == IDLE);
   assign direct  = rise & idle & ~hold_full;
   assign drain   = idle & hold_full;
   assign start   = drain | direct;
   // A new command may take the slot the held command vacates in the same cycle
   assign store   = rise & ~direct & (~hold_full | drain);
   assign drop    = rise & hold_full & ~drain;

   assign s_ctl   = hold_full ? hold_ctl  : cmd_adr[27];
   assign s_idx   = hold_full ? hold_idx  : cmd_adr[2];
   assign s_wadr  = hold_full ? hold_wadr : cmd_adr[ADDR_W+1:2];
   assign s_we    = hold_full ? hold_we   : cmd_we;
   assign s_sel   = hold_full ? hold_sel  : cmd_sel;
   assign s_dat   = hold_full ? hold_dat  : cmd_dat;

   assign ovf_clr    = start & s_ctl & s_we & ~s_idx & s_sel[0] & s_dat[0];
   assign status_val = {29'd0, ~idle, hold_full, ovf};
   assign unused_adr = ^cmd_adr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         prev_val   <= 1'b0;
         ovf        <= 1'b0;
         scratch    <= '0;
         w_sel      <= '0;
         w_dat      <= '0;
         hold_full  <= 1'b0;
         hold_ctl   <= 1'b0;
         hold_idx   <= 1'b0;
         hold_wadr  <= '0;
         hold_we    <= 1'b0;
         hold_sel   <= '0;
         hold_dat   <= '0;
         rd_ack     <= 1'b0;
         rd_dat     <= '0;
         arr_rd_enb <= 1'b0;
         arr_rd_adr <= '0;
         arr_wr_enb <= 1'b0;
         arr_wr_adr <= '0;
         arr_wr_dat <= '0;
      end else begin
         prev_val   <= cmd_val;
         rd_ack     <= 1'b0;
         arr_rd_enb <= 1'b0;
         arr_wr_enb <= 1'b0;

         // a drop beats a clear in the same cycle
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;

         if (store) begin
            hold_full <= 1'b1;
            hold_ctl  <= cmd_adr[27];
            hold_idx  <= cmd_adr[2];
            hold_wadr <= cmd_adr[ADDR_W+1:2];
            hold_we   <= cmd_we;
            hold_sel  <= cmd_sel;
            hold_dat  <= cmd_dat;
         end else if (drain) begin
            hold_full <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  if (s_ctl) begin
                     if (s_we) begin
                        if (s_idx) begin
                           for (int i = 0; i < 4; i++)
                              if (s_sel[i]) scratch[8*i +: 8] <= s_dat[8*i +: 8];
                        end
                     end else begin
                        rd_ack <= 1'b1;
                        rd_dat <= s_idx ? scratch : status_val;
                     end
                  end else if (!s_we) begin
                     arr_rd_enb <= 1'b1;
                     arr_rd_adr <= s_wadr;
                     cnt        <= LAT;
                     state      <= RD_WAIT;
                  end else if (s_sel == 4'hF) begin
                     arr_wr_enb <= 1'b1;
                     arr_wr_adr <= s_wadr;
                     arr_wr_dat <= s_dat;
                  end else if (s_sel != 4'h0) begin
                     arr_rd_enb <= 1'b1;
                     arr_rd_adr <= s_wadr;
                     w_sel      <= s_sel;
                     w_dat      <= s_dat;
                     cnt        <= LAT;
                     state      <= RMW_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt == 3'd0) begin
                  rd_dat <= arr_rd_dat;
                  rd_ack <= 1'b1;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RMW_WAIT: begin
               if (cnt == 3'd0) begin
                  arr_wr_enb <= 1'b1;
                  arr_wr_adr <= arr_rd_adr;
                  arr_wr_dat <= merge(w_sel, w_dat, arr_rd_dat);
                  state      <= RMW_WR;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RMW_WR: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_cmd_ctl.sv
// Directed bench for sram_cmd_ctl with a 1-cycle-latency array model.
module tb_sram_cmd_ctl;
   localparam int ADDR_W = 6;
   localparam int RD_LAT = 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_val = 1'b0;
   logic [31:0]       cmd_adr = '0;
   logic              cmd_we = 1'b0;
   logic [3:0]        cmd_sel = '0;
   logic [31:0]       cmd_dat = '0;
   logic              rd_ack;
   logic [31:0]       rd_dat;
   logic              arr_rd_enb;
   logic [ADDR_W-1:0] arr_rd_adr;
   logic [31:0]       arr_rd_dat;
   logic              arr_wr_enb;
   logic [ADDR_W-1:0] arr_wr_adr;
   logic [31:0]       arr_wr_dat;

   sram_cmd_ctl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .cmd_val(cmd_val), .cmd_adr(cmd_adr), .cmd_we(cmd_we),
      .cmd_sel(cmd_sel), .cmd_dat(cmd_dat), .rd_ack(rd_ack), .rd_dat(rd_dat),
      .arr_rd_enb(arr_rd_enb), .arr_rd_adr(arr_rd_adr), .arr_rd_dat(arr_rd_dat),
      .arr_wr_enb(arr_wr_enb), .arr_wr_adr(arr_wr_adr), .arr_wr_dat(arr_wr_dat)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [64];
   logic [31:0] rd_q = '0;
   always @(posedge clk) begin
      if (arr_wr_enb) mem[arr_wr_adr] <= arr_wr_dat;
      if (arr_rd_enb) rd_q <= mem[arr_rd_adr];
   end
   assign arr_rd_dat = rd_q;

   int cyc = 0;
   int t0 = -10;
   always @(posedge clk) cyc <= cyc + 1;

   int          ack_cyc, rde_cyc, wre_cyc;
   logic [31:0] ack_dat, rde_adr, wre_adr, wre_dat;
   always @(negedge clk) begin
      if (cyc == t0) begin
         ack_cyc = -1; rde_cyc = -1; wre_cyc = -1;
         ack_dat = '0; rde_adr = '0; wre_adr = '0; wre_dat = '0;
      end else begin
         if (rd_ack && ack_cyc < 0) begin ack_cyc = cyc; ack_dat = rd_dat; end
         if (arr_rd_enb && rde_cyc < 0) begin rde_cyc = cyc; rde_adr = 32'(arr_rd_adr); end
         if (arr_wr_enb && wre_cyc < 0) begin
            wre_cyc = cyc; wre_adr = 32'(arr_wr_adr); wre_dat = arr_wr_dat;
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat);
      @(posedge clk); #1;
      cmd_adr = adr; cmd_we = we; cmd_sel = sel; cmd_dat = dat; cmd_val = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      cmd_val = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2 rst = 1'b0;
      #1;
      chk("rst_pulses", {29'd0, rd_ack, arr_rd_enb, arr_wr_enb}, 32'd0);
      chk("rst_rd_dat", rd_dat, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle(2);

      // full write then read back
      send(32'h3000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
      idle(4);
      chk("fw_cyc", 32'(wre_cyc - t0), 32'd1);
      chk("fw_adr", wre_adr, 32'd4);
      chk("fw_dat", wre_dat, 32'hDEAD_BEEF);
      chk("fw_noack", 32'(ack_cyc), 32'hFFFF_FFFF);

      send(32'h0000_0010, 1'b0, 4'h0, 32'h0);
      idle(6);
      chk("rd_enb_cyc", 32'(rde_cyc - t0), 32'd1);
      chk("rd_adr", rde_adr, 32'd4);
      chk("rd_ack_cyc", 32'(ack_cyc - t0), 32'd3);
      chk("rd_dat", ack_dat, 32'hDEAD_BEEF);

      // sel=0 write touches nothing
      send(32'h0000_0010, 1'b1, 4'h0, 32'hFFFF_FFFF);
      idle(4);
      chk("sel0_nowr", 32'(wre_cyc), 32'hFFFF_FFFF);
      chk("sel0_nord", 32'(rde_cyc), 32'hFFFF_FFFF);
      chk("sel0_mem", mem[4], 32'hDEAD_BEEF);

      // read-modify-write
      send(32'h0000_0010, 1'b1, 4'hF, 32'h1122_3344);
      idle(3);
      send(32'h0000_0010, 1'b1, 4'b0101, 32'hAABB_CCDD);
      idle(6);
      chk("rmw_rd_cyc", 32'(rde_cyc - t0), 32'd1);
      chk("rmw_wr_cyc", 32'(wre_cyc - t0), 32'd3);
      chk("rmw_wr_dat", wre_dat, 32'h11BB_33DD);

      // read held behind a partial write to the same word
      send(32'h0000_0014, 1'b1, 4'hF, 32'hCAFE_F00D);
      idle(3);
      send(32'h0000_0014, 1'b1, 4'b1000, 32'h5A00_0000);
      send(32'h0000_0014, 1'b0, 4'h0, 32'h0);
      idle(8);
      chk("raw_ack_cyc", 32'(ack_cyc - t0), 32'd5);
      chk("raw_dat", ack_dat, 32'h5AFE_F00D);

      // overflow: A runs, B held, B drains while C takes its slot, D dropped
      send(32'h0000_0018, 1'b1, 4'hF, 32'h0);
      send(32'h0000_001C, 1'b1, 4'hF, 32'h0707_0707);
      send(32'h0000_0020, 1'b1, 4'hF, 32'h0);
      idle(3);
      send(32'h0000_0018, 1'b1, 4'b0001, 32'h0000_00AA);
      send(32'h0000_0020, 1'b1, 4'b0010, 32'h0000_BB00);
      send(32'h0000_0024, 1'b1, 4'hF, 32'h2424_2424);
      send(32'h0000_001C, 1'b1, 4'hF, 32'h7777_7777);
      @(negedge clk);
      chk("ovf_status_busy", dut.status_val, 32'h7);
      idle(8);
      chk("ovf_mem6", mem[6], 32'h0000_00AA);
      chk("ovf_mem8", mem[8], 32'h0000_BB00);
      chk("ovf_mem9", mem[9], 32'h2424_2424);
      chk("ovf_mem7_drop", mem[7], 32'h0707_0707);
      send(32'h3800_0000, 1'b0, 4'h0, 32'h0);
      idle(3);
      chk("status_ovf", ack_dat, 32'h1);
      send(32'h3800_0000, 1'b1, 4'h1, 32'h1);
      idle(2);
      send(32'h3800_0000, 1'b0, 4'h0, 32'h0);
      idle(3);
      chk("status_clr", ack_dat, 32'h0);

      // scratch with byte enables
      send(32'h3800_0004, 1'b1, 4'b0011, 32'h1234_5678);
      idle(2);
      send(32'h3800_0004, 1'b0, 4'h0, 32'h0);
      idle(3);
      chk("scr_ack_cyc", 32'(ack_cyc - t0), 32'd1);
      chk("scr_dat", ack_dat, 32'h0000_5678);

      // address wrap
      send(32'h3000_0100, 1'b0, 4'h0, 32'h0);
      idle(6);
      chk("wrap_adr", rde_adr, 32'd0);
      chk("wrap_ack_cyc", 32'(ack_cyc - t0), 32'd3);

      // reset while the read is waiting on the array
      send(32'h0000_0010, 1'b0, 4'h0, 32'h0);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_pulses", {29'd0, rd_ack, arr_rd_enb, arr_wr_enb}, 32'd0);
      chk("mid_rst_rd_dat", rd_dat, 32'd0);
      chk("mid_rst_rd_adr", 32'(arr_rd_adr), 32'd0);
      chk("mid_rst_wr_dat", arr_wr_dat, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle(6);
      chk("mid_rst_noack", 32'(ack_cyc), 32'hFFFF_FFFF);
      send(32'h3800_0000, 1'b0, 4'h0, 32'h0);
      idle(3);
      chk("post_rst_status", ack_dat, 32'h0);
      send(32'h3800_0004, 1'b0, 4'h0, 32'h0);
      idle(3);
      chk("post_rst_scratch", ack_dat, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
